// File: rtl/sm_hex_display_mux.sv
// sm_hex_display_mux
//   Time-multiplexed driver for DIGITS seven-segment digits sharing one
//   segment bus. A packed hex value is captured into a pending buffer on
//   `load` and promoted to the display buffer only at a frame boundary,
//   so a frame is never drawn from a mix of old and new data.
//
// Ports
//   clk            in   system clock
//   rst            in   synchronous, active-high reset
//   number         in   DIGITS*4  hex value, digit i = number[4i+3:4i]
//   dots           in   DIGITS    decimal point request per digit
//   load           in   capture number/dots into the pending buffer
//   blank_lz       in   blank leading zero digits (digit 0 never blanked)
//   seven_segments out  7         segment drive, bit0=a .. bit6=g
//   dot            out  decimal point drive
//   anodes         out  DIGITS    one-hot digit select
//   frame_done     out  one-cycle pulse at the frame boundary
module sm_hex_display_mux #(
  parameter int unsigned DIGITS         = 8,
  parameter int unsigned SCAN_DIV       = 50000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DIGITS*4-1:0]   number,
  input  logic [DIGITS-1:0]     dots,
  input  logic                  load,
  input  logic                  blank_lz,
  output logic [6:0]            seven_segments,
  output logic                  dot,
  output logic [DIGITS-1:0]     anodes,
  output logic                  frame_done
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  // XOR masks: lit pattern ^ mask gives the pin level; mask alone is "off".
  localparam logic [6:0]        SEG_OFF = {7{SEG_ACTIVE_LOW}};
  localparam logic [DIGITS-1:0] AN_OFF  = {DIGITS{AN_ACTIVE_LOW}};

  logic [PW-1:0]         presc_q, presc_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [DIGITS*4-1:0]   pend_num_q, pend_num_d;
  logic [DIGITS-1:0]     pend_dots_q, pend_dots_d;
  logic                  pend_vld_q, pend_vld_d;
  logic [DIGITS*4-1:0]   disp_num_q, disp_num_d;
  logic [DIGITS-1:0]     disp_dots_q, disp_dots_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dot_q, dot_d;
  logic [DIGITS-1:0]     an_q, an_d;
  logic                  fd_q, fd_d;

  logic                  wrap, last;
  logic [DIGITS-1:0]     blank_vec;
  logic                  zero_run;
  logic [3:0]            cur_nib;
  logic                  cur_dot, cur_blank;
  logic [DIGITS-1:0]     an_hot;
  logic [6:0]            lit;

  function automatic logic [6:0] hex_lit(input logic [3:0] h);
    case (h)
      4'h0: hex_lit = 7'h3F;
      4'h1: hex_lit = 7'h06;
      4'h2: hex_lit = 7'h5B;
      4'h3: hex_lit = 7'h4F;
      4'h4: hex_lit = 7'h66;
      4'h5: hex_lit = 7'h6D;
      4'h6: hex_lit = 7'h7D;
      4'h7: hex_lit = 7'h07;
      4'h8: hex_lit = 7'h7F;
      4'h9: hex_lit = 7'h6F;
      4'hA: hex_lit = 7'h77;
      4'hB: hex_lit = 7'h7C;
      4'hC: hex_lit = 7'h39;
      4'hD: hex_lit = 7'h5E;
      4'hE: hex_lit = 7'h79;
      default: hex_lit = 7'h71;
    endcase
  endfunction

  assign wrap = (presc_q == PW'(SCAN_DIV - 1));
  assign last = (idx_q == IW'(DIGITS - 1));

  // Walk from the top digit down; a digit is blanked while every digit
  // from the top down to it is zero.
  always_comb begin
    blank_vec = '0;
    zero_run  = 1'b1;
    for (int unsigned j = 0; j < DIGITS; j++) begin
      zero_run = zero_run & (disp_num_q[4*(DIGITS-1-j) +: 4] == 4'h0);
      if (j != DIGITS - 1) blank_vec[DIGITS-1-j] = blank_lz & zero_run;
    end
  end

  always_comb begin
    cur_nib   = '0;
    cur_dot   = 1'b0;
    cur_blank = 1'b0;
    an_hot    = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        cur_nib   = disp_num_q[4*i +: 4];
        cur_dot   = disp_dots_q[i];
        cur_blank = blank_vec[i];
        an_hot[i] = 1'b1;
      end
    end
    lit = hex_lit(cur_nib) & {7{~cur_blank}};
  end

  // The output register latches the digit at idx_q on the wrap edge while
  // idx_q moves on, so the pins show slot k during the (k+1)th prescaler
  // period. The frame_done cycle therefore coincides with the last digit
  // already latched; promoting pending at the end of that cycle only
  // affects the next frame.
  always_comb begin
    presc_d     = wrap ? '0 : presc_q + PW'(1);
    idx_d       = idx_q;
    seg_d       = seg_q;
    dot_d       = dot_q;
    an_d        = an_q;
    fd_d        = 1'b0;
    pend_num_d  = pend_num_q;
    pend_dots_d = pend_dots_q;
    pend_vld_d  = pend_vld_q;
    disp_num_d  = disp_num_q;
    disp_dots_d = disp_dots_q;

    if (wrap) begin
      idx_d = last ? '0 : idx_q + IW'(1);
      seg_d = lit ^ SEG_OFF;
      dot_d = cur_dot ^ SEG_ACTIVE_LOW;
      an_d  = an_hot ^ AN_OFF;
      fd_d  = last;
    end

    if (fd_q && pend_vld_q) begin
      disp_num_d  = pend_num_q;
      disp_dots_d = pend_dots_q;
      pend_vld_d  = 1'b0;
    end
    if (load) begin
      pend_num_d  = number;
      pend_dots_d = dots;
      pend_vld_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q     <= '0;
      idx_q       <= '0;
      pend_num_q  <= '0;
      pend_dots_q <= '0;
      pend_vld_q  <= 1'b0;
      disp_num_q  <= '0;
      disp_dots_q <= '0;
      seg_q       <= SEG_OFF;
      dot_q       <= SEG_ACTIVE_LOW;
      an_q        <= AN_OFF;
      fd_q        <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      idx_q       <= idx_d;
      pend_num_q  <= pend_num_d;
      pend_dots_q <= pend_dots_d;
      pend_vld_q  <= pend_vld_d;
      disp_num_q  <= disp_num_d;
      disp_dots_q <= disp_dots_d;
      seg_q       <= seg_d;
      dot_q       <= dot_d;
      an_q        <= an_d;
      fd_q        <= fd_d;
    end
  end

  assign seven_segments = seg_q;
  assign dot            = dot_q;
  assign anodes         = an_q;
  assign frame_done     = fd_q;

endmodule

// File: tb/tb_sm_hex_display_mux.sv
module tb_sm_hex_display_mux;

  localparam int unsigned D  = 4;
  localparam int unsigned SD = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [15:0]   number = '0;
  logic [3:0]    dots = '0;
  logic          load = 1'b0;
  logic          blank_lz = 1'b0;

  logic [6:0]    seg_n, seg_p;
  logic          dot_n, dot_p;
  logic [3:0]    an_n, an_p;
  logic          fd_n, fd_p;

  int ncmp = 0;
  int nfail = 0;
  int cyc = 0;
  bit started = 1'b0;

  sm_hex_display_mux #(.DIGITS(D), .SCAN_DIV(SD), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) u_dut (
    .clk(clk), .rst(rst), .number(number), .dots(dots), .load(load), .blank_lz(blank_lz),
    .seven_segments(seg_n), .dot(dot_n), .anodes(an_n), .frame_done(fd_n));

  sm_hex_display_mux #(.DIGITS(D), .SCAN_DIV(SD), .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0)) u_dut_pos (
    .clk(clk), .rst(rst), .number(number), .dots(dots), .load(load), .blank_lz(blank_lz),
    .seven_segments(seg_p), .dot(dot_p), .anodes(an_p), .frame_done(fd_p));

  always #5 clk = ~clk;

  // ---------------- behavioural model (active-high lit patterns) -------------
  string seg_names[16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                           "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};
  logic [6:0] lit_tab[16];

  int          n;            // cycles since reset released
  logic [15:0] m_pend, m_disp;
  logic [3:0]  m_pdots, m_ddots;
  bit          m_pv;
  logic [6:0]  m_seg;        // lit segments
  bit          m_dot;        // lit dot
  logic [3:0]  m_an;         // selected digit, 0 = none
  bit          m_fd;

  initial begin
    for (int h = 0; h < 16; h++) begin
      lit_tab[h] = '0;
      for (int c = 0; c < seg_names[h].len(); c++)
        lit_tab[h][seg_names[h][c] - "a"] = 1'b1;
    end
  end

  always @(posedge clk) begin
    logic [15:0] od;
    logic [3:0]  odd;
    bit          ofd;
    int          k;
    started <= 1'b1;
    cyc = cyc + 1;
    if (rst) begin
      n = 0; m_pend = '0; m_disp = '0; m_pdots = '0; m_ddots = '0; m_pv = 0;
      m_seg = '0; m_dot = 0; m_an = '0; m_fd = 0;
    end else begin
      od = m_disp; odd = m_ddots; ofd = m_fd;
      if (ofd && m_pv) begin m_disp = m_pend; m_ddots = m_pdots; m_pv = 0; end
      if (load) begin m_pend = number; m_pdots = dots; m_pv = 1; end
      if (n % SD == SD - 1) begin
        k = (n / SD) % D;
        m_an  = 4'(1 << k);
        m_dot = odd[k];
        if (blank_lz && k > 0 && (od >> (4 * k)) == 0) m_seg = '0;
        else m_seg = lit_tab[(od >> (4 * k)) & 15];
        m_fd = (k == D - 1);
      end else begin
        m_fd = 0;
      end
      n = n + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Every-cycle compare of both polarity builds against the model.
  always @(negedge clk) begin
    if (started) begin
      chk("seg_lowpol", {25'd0, seg_n}, {25'd0, ~m_seg});
      chk("dot_lowpol", {31'd0, dot_n}, {31'd0, ~m_dot});
      chk("an_lowpol",  {28'd0, an_n},  {28'd0, ~m_an});
      chk("fd_lowpol",  {31'd0, fd_n},  {31'd0, m_fd});
      chk("seg_highpol", {25'd0, seg_p}, {25'd0, m_seg});
      chk("dot_highpol", {31'd0, dot_p}, {31'd0, m_dot});
      chk("an_highpol",  {28'd0, an_p},  {28'd0, m_an});
      chk("fd_highpol",  {31'd0, fd_p},  {31'd0, m_fd});
    end
  end

  // ---------------- directed helpers ----------------
  task automatic wait_fd(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (fd_n === 1'b1) break;
    end
    if (i == budget) chk("wait_frame_done_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_an(input logic [3:0] pat, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (an_n === pat) break;
    end
    if (i == budget) chk("wait_anode_timeout", {28'd0, an_n}, {28'd0, pat});
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    number = v; dots = d; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic check_frame(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                             input logic [6:0] s2, input logic [6:0] s3);
    wait_an(4'b1110, 40); chk({tag, "_d0"}, {25'd0, seg_n}, {25'd0, s0});
    wait_an(4'b1101, 40); chk({tag, "_d1"}, {25'd0, seg_n}, {25'd0, s1});
    wait_an(4'b1011, 40); chk({tag, "_d2"}, {25'd0, seg_n}, {25'd0, s2});
    wait_an(4'b0111, 40); chk({tag, "_d3"}, {25'd0, seg_n}, {25'd0, s3});
  endtask

  initial begin
    int c0, t1, t2;
    // Reset
    repeat (3) begin
      @(negedge clk);
      chk("rst_anodes", {28'd0, an_n}, 32'h0000000F);
      chk("rst_seg", {25'd0, seg_n}, 32'h0000007F);
      chk("rst_fd", {31'd0, fd_n}, 32'd0);
    end
    rst = 1'b0;
    c0 = cyc;
    wait_an(4'b1110, 20);
    chk("first_wrap_latency", cyc - c0, 32'd4);
    chk("first_seg", {25'd0, seg_n}, 32'h00000040);
    chk("first_dot", {31'd0, dot_n}, 32'd1);

    // Scan: data appears only in the frame after the boundary
    do_load(16'h12AF, 4'b0100);
    wait_fd(40);
    wait_an(4'b1110, 40);
    chk("scan_d0", {25'd0, seg_n}, {25'd0, 7'b0001110});
    wait_an(4'b1101, 40);
    chk("scan_d1", {25'd0, seg_n}, {25'd0, 7'b0001000});
    wait_an(4'b1011, 40);
    chk("scan_d2", {25'd0, seg_n}, {25'd0, 7'b0100100});
    chk("scan_d2_dot", {31'd0, dot_n}, 32'd0);
    wait_an(4'b0111, 40);
    chk("scan_d3", {25'd0, seg_n}, {25'd0, 7'b1111001});
    wait_fd(40); t1 = cyc;
    wait_fd(40); t2 = cyc;
    chk("frame_period", t2 - t1, 32'd16);

    // Tear-free: two loads mid-frame, last wins next frame
    dots = '0;
    repeat (5) @(negedge clk);
    do_load(16'h1111, 4'b0000);
    @(negedge clk);
    do_load(16'h2222, 4'b0000);
    wait_fd(40);
    check_frame("tear", 7'b0100100, 7'b0100100, 7'b0100100, 7'b0100100);

    // Leading-zero blanking
    blank_lz = 1'b1;
    do_load(16'h0030, 4'b0000);
    wait_fd(40);
    check_frame("blank30", 7'b1000000, 7'b0110000, 7'b1111111, 7'b1111111);
    do_load(16'h0000, 4'b0000);
    wait_fd(40);
    check_frame("blank00", 7'b1000000, 7'b1111111, 7'b1111111, 7'b1111111);

    // Load on the frame_done cycle
    do_load(16'h00AA, 4'b0000);
    wait_fd(40);
    do_load(16'h0055, 4'b0000);
    wait_an(4'b1110, 40);
    chk("simul_old", {25'd0, seg_n}, {25'd0, 7'b0001000});
    wait_fd(40);
    wait_an(4'b1110, 40);
    chk("simul_new", {25'd0, seg_n}, {25'd0, 7'b0010010});

    // Randomized phase, model-checked every cycle
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      load   = ($urandom_range(0, 5) == 0);
      number = 16'($urandom);
      if ($urandom_range(0, 2) == 0) number[15:8] = '0;
      dots   = 4'($urandom);
      if ($urandom_range(0, 49) == 0) blank_lz = ~blank_lz;
      rst    = ($urandom_range(0, 399) == 0);
    end
    @(negedge clk);
    rst = 1'b0; load = 1'b0;
    repeat (40) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/sm_hex_display_mux.md
Name: sm_hex_display_mux

Overview:
- Time-multiplexed driver for a bank of DIGITS common-anode/cathode 7-segment digits sharing one segment bus.
- Takes a packed hex value, double-buffers it, and scans one digit per scan period.
- Adds per-digit decimal points, optional leading-zero blanking and tear-free frame-synchronous update.
- Sits between the CPU output port register (or debug bus) and the board display pins.

Parameters:
- DIGITS, 8, number of hex digits driven (1..16).
- SCAN_DIV, 50000, clk cycles per digit slot (>=2).
- SEG_ACTIVE_LOW, 1, 1 = segment/dot outputs low when lit; 0 = high when lit.
- AN_ACTIVE_LOW, 1, 1 = anode select low for the active digit; 0 = high.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- number  in  DIGITS*4  value to show; digit i = number[4i+3:4i], digit 0 rightmost.
- dots  in  DIGITS  decimal point request per digit, bit i = digit i.
- load  in  1  strobe: capture number/dots into the pending buffer this cycle.
- blank_lz  in  1  1 = blank leading zero digits (digit 0 never blanked).
- seven_segments  out  7  segment drive, bit0=a ... bit6=g, polarity per SEG_ACTIVE_LOW.
- dot  out  1  decimal point drive, polarity per SEG_ACTIVE_LOW.
- anodes  out  DIGITS  digit select, one-hot active, polarity per AN_ACTIVE_LOW.
- frame_done  out  1  one-cycle pulse when the last digit slot ends.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values:
  - prescaler=0, digit index=0, pending and display buffers cleared, pending_valid=0.
  - All outputs registered and inactive at reset: anodes all deselected, seven_segments all unlit, dot unlit, frame_done=0.
- Prescaler:
  - Counts 0..SCAN_DIV-1 and wraps.
  - On wrap, the digit index advances: 0 -> 1 -> ... -> DIGITS-1 -> 0.
- frame_done pulses high for exactly the cycle in which the index wraps DIGITS-1 -> 0.
- Double buffering:
  - load=1 copies number/dots into the pending buffer and sets pending_valid. Repeated loads overwrite; the last one wins.
  - On the frame_done cycle with pending_valid set, pending is copied to the display buffer and pending_valid is cleared.
  - load in that same cycle: the new data goes to pending with pending_valid=1, and the old pending is transferred.
  - A frame is therefore never shown half-old/half-new.
- Decode:
  - Hex 0-F maps to the standard segment set (lit segments):
    0 abcdef, 1 bc, 2 abdeg, 3 abcdg, 4 bcfg, 5 acdfg, 6 acdefg, 7 abc, 8 all, 9 abcdfg, A abcefg, b cdefg, C adef, d bcdeg, E adefg, F aefg.
  - Polarity is applied after decode.
- Leading-zero blanking:
  - When blank_lz=1, digit i (i>0) is blanked if it and every digit above it are zero in the display buffer.
  - A blanked digit drives segments unlit but still honours its dot bit.
  - blank_lz is sampled live, not buffered.
- Timing:
  - Outputs are registered.
  - anodes/seven_segments/dot reflect the new index one clk after the prescaler wrap.
  - All three change in the same cycle; the anode is never active with another digit's segments.
- Reset mid-scan returns to index 0 next cycle, and buffers clear; the first display after reset shows 0 (or blank digits above 0 if blank_lz).
- DIGITS=1: index stays 0, and frame_done pulses every SCAN_DIV cycles.

Test Plan:
- Reset:
  - Stimulus: DIGITS=4, SCAN_DIV=4; hold rst 3 cycles, release.
  - Required: anodes=4'b1111 and seven_segments=7'b1111111 during reset; 1 cycle after the first wrap, anodes=4'b1110 and seven_segments=7'b1000000.
- Scan:
  - Stimulus: load number=16'h12AF, dots=4'b0100, then run two frames.
  - Required in frame 1: digits still 0, data not visible.
  - Required in frame 2: digit0 7'b0001110, digit1 7'b0001000, digit2 7'b0100100 with dot=0, digit3 7'b1111001; anodes cycle 1110, 1101, 1011, 0111; frame_done pulses once per 16 cycles.
- Tear-free:
  - Stimulus: load 16'h1111 mid-frame, then 16'h2222 two cycles later.
  - Required: the current frame is unchanged, and the next frame shows 2 on all digits.
- Blanking:
  - Stimulus: number=16'h0030, blank_lz=1.
  - Required: digits 3 and 2 are 7'b1111111, digit1 is 7'b0110000, digit0 is 7'b1000000.
  - Stimulus: number=16'h0000.
  - Required: only digit0 is lit ('0').
- Simultaneous events and polarity:
  - Stimulus: load asserted on the frame_done cycle.
  - Required: the old pending value is displayed next frame, and the new value the frame after.
  - Stimulus: rebuild with SEG_ACTIVE_LOW=0, AN_ACTIVE_LOW=0.
  - Required: all outputs are the bitwise inverse of the default build's outputs.
